// File: rtl/axil_ram.sv
// AXI4-Lite single-port RAM with byte strobes and optional extra read-data register stage.
// Write and read channels are independent; same-edge read/write of one word returns old data.
module axil_ram #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 5,
    parameter int STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int PIPELINE_OUTPUT = 0
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,

    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready
);

    localparam int WordLsb  = $clog2(STRB_WIDTH);
    localparam int IdxWidth = ADDR_WIDTH - WordLsb;
    localparam int Words    = 2 ** IdxWidth;

    logic [DATA_WIDTH-1:0] mem [Words];

    logic                  aw_fire;
    logic                  ar_fire;
    logic                  bvalid_q;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [IdxWidth-1:0]   aw_idx;
    logic [IdxWidth-1:0]   ar_idx;

    assign aw_idx = s_axil_awaddr[ADDR_WIDTH-1:WordLsb];
    assign ar_idx = s_axil_araddr[ADDR_WIDTH-1:WordLsb];

    // AW and W are only ever accepted together; gating with rst keeps readies low in reset.
    assign s_axil_awready = rst & s_axil_awvalid & s_axil_wvalid & (!bvalid_q | s_axil_bready);
    assign s_axil_wready  = s_axil_awready;
    assign aw_fire        = s_axil_awready;
    assign ar_fire        = s_axil_arready;

    assign s_axil_bvalid = bvalid_q;
    assign s_axil_bresp  = 2'b00;
    assign s_axil_rvalid = rvalid_q;
    assign s_axil_rdata  = rdata_q;
    assign s_axil_rresp  = 2'b00;

    // Memory is deliberately not reset so contents survive a mid-run reset.
    always_ff @(posedge clk) begin
        if (aw_fire) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (s_axil_wstrb[i]) begin
                    mem[aw_idx][8*i +: 8] <= s_axil_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bvalid_q <= 1'b0;
        end else if (aw_fire) begin
            bvalid_q <= 1'b1;
        end else if (s_axil_bready) begin
            bvalid_q <= 1'b0;
        end
    end

    if (PIPELINE_OUTPUT != 0) begin : g_pipe
        logic                  s1_valid_q;
        logic [DATA_WIDTH-1:0] s1_data_q;
        logic                  out_ready;

        assign out_ready      = !rvalid_q | s_axil_rready;
        assign s_axil_arready = rst & s_axil_arvalid & (!s1_valid_q | out_ready);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                s1_valid_q <= 1'b0;
                s1_data_q  <= '0;
                rvalid_q   <= 1'b0;
                rdata_q    <= '0;
            end else begin
                if (out_ready) begin
                    rvalid_q <= s1_valid_q;
                    if (s1_valid_q) begin
                        rdata_q <= s1_data_q;
                    end
                end
                if (ar_fire) begin
                    s1_valid_q <= 1'b1;
                    s1_data_q  <= mem[ar_idx];
                end else if (out_ready) begin
                    s1_valid_q <= 1'b0;
                end
            end
        end
    end else begin : g_direct
        assign s_axil_arready = rst & s_axil_arvalid & (!rvalid_q | s_axil_rready);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rvalid_q <= 1'b0;
                rdata_q  <= '0;
            end else if (ar_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= mem[ar_idx];
            end else if (s_axil_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    logic unused_prot;
    assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

    if (WordLsb > 0) begin : g_lsb
        logic unused_lsb;
        assign unused_lsb = ^{s_axil_awaddr[WordLsb-1:0], s_axil_araddr[WordLsb-1:0]};
    end

endmodule

// File: tb/tb_axil_ram.sv
// Directed bench for axil_ram (default parameters) with a read-data scoreboard
// fed from a reference memory model updated on observed handshakes.
module tb_axil_ram;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  s_axil_awaddr;
    logic [2:0]  s_axil_awprot;
    logic        s_axil_awvalid;
    logic        s_axil_awready;
    logic [31:0] s_axil_wdata;
    logic [3:0]  s_axil_wstrb;
    logic        s_axil_wvalid;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready;
    logic [4:0]  s_axil_araddr;
    logic [2:0]  s_axil_arprot;
    logic        s_axil_arvalid;
    logic        s_axil_arready;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid;
    logic        s_axil_rready;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [8];
    logic [31:0] exp_q [$];

    axil_ram dut (
        .clk            (clk),
        .rst            (rst),
        .s_axil_awaddr  (s_axil_awaddr),
        .s_axil_awprot  (s_axil_awprot),
        .s_axil_awvalid (s_axil_awvalid),
        .s_axil_awready (s_axil_awready),
        .s_axil_wdata   (s_axil_wdata),
        .s_axil_wstrb   (s_axil_wstrb),
        .s_axil_wvalid  (s_axil_wvalid),
        .s_axil_wready  (s_axil_wready),
        .s_axil_bresp   (s_axil_bresp),
        .s_axil_bvalid  (s_axil_bvalid),
        .s_axil_bready  (s_axil_bready),
        .s_axil_araddr  (s_axil_araddr),
        .s_axil_arprot  (s_axil_arprot),
        .s_axil_arvalid (s_axil_arvalid),
        .s_axil_arready (s_axil_arready),
        .s_axil_rdata   (s_axil_rdata),
        .s_axil_rresp   (s_axil_rresp),
        .s_axil_rvalid  (s_axil_rvalid),
        .s_axil_rready  (s_axil_rready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: pop before push, and model reads before writes (read-first).
    always @(negedge clk) begin
        if (s_axil_rvalid && s_axil_rready) begin
            check("r_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("rdata", s_axil_rdata, exp_q.pop_front());
                check("rresp", 32'(s_axil_rresp), 32'd0);
            end
        end
        if (s_axil_arvalid && s_axil_arready) begin
            exp_q.push_back(model[s_axil_araddr[4:2]]);
        end
        if (s_axil_awvalid && s_axil_awready) begin
            for (int i = 0; i < 4; i++) begin
                if (s_axil_wstrb[i]) model[s_axil_awaddr[4:2]][8*i +: 8] = s_axil_wdata[8*i +: 8];
            end
        end
    end

    task automatic wait_aw;
        int n = 0;
        @(negedge clk);
        while (!s_axil_awready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("aw_timeout", 32'(s_axil_awready), 32'd1);
    endtask

    task automatic wait_ar;
        int n = 0;
        @(negedge clk);
        while (!s_axil_arready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ar_timeout", 32'(s_axil_arready), 32'd1);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        s_axil_awaddr  = a;
        s_axil_wdata   = d;
        s_axil_wstrb   = s;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        wait_aw();
        @(posedge clk);
        #1;
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] a);
        s_axil_araddr  = a;
        s_axil_arvalid = 1'b1;
        wait_ar();
        @(posedge clk);
        #1;
        s_axil_arvalid = 1'b0;
    endtask

    task automatic drain;
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b0;
        s_axil_awaddr  = 5'h04;
        s_axil_awprot  = 3'b000;
        s_axil_wdata   = 32'h0000_0929;
        s_axil_wstrb   = 4'hF;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        s_axil_bready  = 1'b1;
        s_axil_araddr  = 5'h00;
        s_axil_arprot  = 3'b000;
        s_axil_arvalid = 1'b1;
        s_axil_rready  = 1'b1;

        // Reset state with all valids driven high
        repeat (2) @(negedge clk);
        check("rst_awready", 32'(s_axil_awready), 32'd0);
        check("rst_wready", 32'(s_axil_wready), 32'd0);
        check("rst_arready", 32'(s_axil_arready), 32'd0);
        check("rst_bvalid", 32'(s_axil_bvalid), 32'd0);
        check("rst_rvalid", 32'(s_axil_rvalid), 32'd0);
        check("rst_rdata", s_axil_rdata, 32'd0);
        check("rst_bresp", 32'(s_axil_bresp), 32'd0);
        check("rst_rresp", 32'(s_axil_rresp), 32'd0);
        s_axil_arvalid = 1'b0;

        // Release reset mid-cycle: readies rise in the same cycle, write lands next edge
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rel_awready", 32'(s_axil_awready), 32'd1);
        check("rel_wready", 32'(s_axil_wready), 32'd1);
        @(posedge clk);
        #1;
        check("w1_bvalid", 32'(s_axil_bvalid), 32'd1);
        check("w1_bresp", 32'(s_axil_bresp), 32'd0);
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        @(posedge clk);
        #1;
        check("w1_bvalid_clr", 32'(s_axil_bvalid), 32'd0);

        do_read(5'h04);
        check("r1_rvalid", 32'(s_axil_rvalid), 32'd1);
        check("r1_rdata", s_axil_rdata, 32'h0000_0929);
        drain();

        // Partial strobes and ignored byte offset
        do_write(5'h08, 32'hAABB_CCDD, 4'hF);
        do_write(5'h08, 32'h1122_3344, 4'h5);
        do_read(5'h08);
        check("strb_rdata", s_axil_rdata, 32'hAA22_CC44);
        drain();
        do_read(5'h0B);
        check("offs_rdata", s_axil_rdata, 32'hAA22_CC44);
        drain();

        // Write backpressure: second request stalls until bready
        s_axil_bready = 1'b0;
        do_write(5'h10, 32'h5555_0001, 4'hF);
        check("bp_bvalid", 32'(s_axil_bvalid), 32'd1);
        s_axil_awaddr  = 5'h14;
        s_axil_wdata   = 32'h5555_0002;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_awready", 32'(s_axil_awready), 32'd0);
            check("bp_bvalid_hold", 32'(s_axil_bvalid), 32'd1);
        end
        s_axil_bready = 1'b1;
        #1;
        check("bp_awready_rel", 32'(s_axil_awready), 32'd1);
        @(posedge clk);
        #1;
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        check("bp_bvalid_b2b", 32'(s_axil_bvalid), 32'd1);
        @(posedge clk);
        #1;
        check("bp_bvalid_clr", 32'(s_axil_bvalid), 32'd0);

        // Read backpressure: rdata stable, arready low until rready
        s_axil_rready = 1'b0;
        do_read(5'h04);
        s_axil_araddr  = 5'h08;
        s_axil_arvalid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rbp_arready", 32'(s_axil_arready), 32'd0);
            check("rbp_rvalid", 32'(s_axil_rvalid), 32'd1);
            check("rbp_rdata", s_axil_rdata, 32'h0000_0929);
        end
        @(posedge clk);
        #1 s_axil_rready = 1'b1;
        @(negedge clk);
        check("rbp_arready_rel", 32'(s_axil_arready), 32'd1);
        @(posedge clk);
        #1;
        s_axil_arvalid = 1'b0;
        check("rbp_rvalid_next", 32'(s_axil_rvalid), 32'd1);
        drain();

        // Back-to-back writes to all words, then back-to-back reads
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        s_axil_wstrb   = 4'hF;
        for (int i = 0; i < 8; i++) begin
            s_axil_awaddr = 5'(i * 4);
            s_axil_wdata  = 32'hC0DE_0000 + 32'(i * 32'h0101) + 32'(i << 24);
            @(negedge clk);
            check("b2b_awready", 32'(s_axil_awready), 32'd1);
            if (i > 0) check("b2b_bvalid", 32'(s_axil_bvalid), 32'd1);
            @(posedge clk);
            #1;
        end
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_bvalid_clr", 32'(s_axil_bvalid), 32'd0);

        s_axil_arvalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_axil_araddr = 5'(i * 4);
            @(negedge clk);
            check("b2b_arready", 32'(s_axil_arready), 32'd1);
            if (i > 0) check("b2b_rvalid", 32'(s_axil_rvalid), 32'd1);
            @(posedge clk);
            #1;
        end
        s_axil_arvalid = 1'b0;
        drain();

        // Reset during a pending read response
        s_axil_rready = 1'b0;
        do_read(5'h0C);
        check("prst_rvalid_pre", 32'(s_axil_rvalid), 32'd1);
        s_axil_arvalid = 1'b1;
        rst = 1'b0;
        #1;
        check("prst_rvalid", 32'(s_axil_rvalid), 32'd0);
        check("prst_rdata", s_axil_rdata, 32'd0);
        check("prst_arready", 32'(s_axil_arready), 32'd0);
        exp_q.delete();
        @(negedge clk);
        #1;
        rst            = 1'b1;
        s_axil_arvalid = 1'b0;
        s_axil_rready  = 1'b1;
        @(posedge clk);
        #1;

        s_axil_arvalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_axil_araddr = 5'(i * 4);
            @(negedge clk);
            check("ret_arready", 32'(s_axil_arready), 32'd1);
            @(posedge clk);
            #1;
        end
        s_axil_arvalid = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axil_ram.md
AXIL_RAM -- requirements
Module: axil_ram

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data bus width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 5, byte-address width.
REQ-003 Parameter STRB_WIDTH, default DATA_WIDTH/8, byte-strobe width.
REQ-004 Parameter PIPELINE_OUTPUT, default 0, adds one read-data register stage when 1.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 s_axil_awaddr  in  ADDR_WIDTH  write byte address.
REQ-009 s_axil_awprot  in  3  ignored.
REQ-010 s_axil_awvalid / s_axil_awready  in / out  1 each  write-address handshake.
REQ-011 s_axil_wdata  in  DATA_WIDTH  write data.
REQ-012 s_axil_wstrb  in  STRB_WIDTH  byte enables; bit i enables wdata[8i+7:8i].
REQ-013 s_axil_wvalid / s_axil_wready  in / out  1 each  write-data handshake.
REQ-014 s_axil_bresp  out  2  write response; s_axil_bvalid out 1; s_axil_bready in 1.
REQ-015 s_axil_araddr  in  ADDR_WIDTH  read byte address; s_axil_arprot in 3, ignored.
REQ-016 s_axil_arvalid / s_axil_arready  in / out  1 each  read-address handshake.
REQ-017 s_axil_rdata  out  DATA_WIDTH; s_axil_rresp out 2; s_axil_rvalid out 1; s_axil_rready in 1.

Function
REQ-018 Storage SHALL be 2^(ADDR_WIDTH - log2(STRB_WIDTH)) words of DATA_WIDTH bits (8 x 32 at defaults); word index = addr[ADDR_WIDTH-1:log2(STRB_WIDTH)], low byte-offset bits ignored, no out-of-range case exists.
REQ-019 awready and wready SHALL be combinational, identical, and equal to awvalid & wvalid & (!bvalid | bready) while not in reset; AW and W are accepted only together.
REQ-020 On an edge with awvalid & awready, each byte whose wstrb bit is 1 SHALL be written; bytes with strobe 0 SHALL be unchanged.
REQ-021 bvalid SHALL assert the cycle after write acceptance, hold until bvalid & bready, and bresp SHALL be 2'b00 (OKAY).
REQ-022 A new write accepted on the same edge that the pending B handshake completes SHALL keep bvalid high (back-to-back, one write per cycle).
REQ-023 arready SHALL be combinational, equal to arvalid & (!rvalid | rready) while not in reset (PIPELINE_OUTPUT=0).
REQ-024 PIPELINE_OUTPUT=0: rdata/rvalid SHALL be registered, valid one cycle after AR acceptance; rdata held stable while rvalid & !rready.
REQ-025 PIPELINE_OUTPUT=1: a second output register SHALL give two-cycle latency; arready SHALL be deasserted whenever either stage holds data that cannot advance.
REQ-026 rresp SHALL be 2'b00 (OKAY) always.
REQ-027 Read and write channels SHALL operate independently; a same-edge read and write to one word SHALL return the old data (read-first).
REQ-028 Write and read addresses are sampled only at their handshake edge.

Reset
REQ-029 While rst=0: awready, wready, arready, bvalid, rvalid = 0; bresp, rresp = 0; rdata = 0; pipeline stages empty.
REQ-030 Asserting rst mid-transaction SHALL immediately drop bvalid and rvalid and discard pending responses; memory contents SHALL not be cleared and are undefined after power-up.
REQ-031 After rst deasserts, the first handshake SHALL be possible on the first rising edge.

Verification
REQ-032 rst=0, awvalid=wvalid=1 -> awready=wready=0, bvalid=0; release rst -> awready=wready=1 in the same cycle.
REQ-033 Write awaddr=0x04, wdata=2345 (0x929), wstrb=0xF, bready=1 -> bvalid=1, bresp=0 next cycle; then read araddr=0x04, rready=1 -> rvalid=1, rdata=0x00000929 one cycle later.
REQ-034 Write 0xAABBCCDD to 0x08, then 0x11223344 with wstrb=0x5 -> read 0x08 returns 0xAA22CC44; read 0x0B returns the same word.
REQ-035 bready=0 after a write -> bvalid held, awready=0 for a second request until bready=1; rready=0 -> rdata stable, arready=0.
REQ-036 Writes to all 8 words with distinct data, back-to-back, then back-to-back reads -> one result per cycle, all matching; assert rst during a pending read -> rvalid=0 immediately, memory data retained.
